ula_arbitro: RTL
================

Name: ula_arbitro

Overview:
- Shares the single 8-bit ALU (5-bit operation selector; results available combinationally in the same cycle) between two requesters: requester 0 is the control unit and requester 1 is the auxiliary/DMA path.
- Round-robin arbitration with a req/gnt handshake.
- Latches the winning operands, drives the ALU for one cycle, then registers the result, carry, zero and error flags.
- Returns the result to the winner with a one-cycle valid pulse.

Parameters:
- LARGURA, 8: operand/result width.
- OP_W, 5: opcode width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  request from requester 0.
- op0  in  OP_W  opcode, requester 0.
- a0, b0  in  LARGURA  operands, requester 0.
- gnt0  out  1  grant pulse, requester 0.
- valido0  out  1  result-valid pulse, requester 0.
- req1, op1, a1, b1, gnt1, valido1: same as above, for requester 1.
- ula_a, ula_b  out  LARGURA  operands driven to the ALU.
- ula_sel  out  OP_W  selector driven to the ALU.
- ula_saida  in  LARGURA  ALU result.
- ula_carry  in  1  ALU carry.
- resultado  out  LARGURA  registered result.
- carry  out  1  registered carry.
- zero  out  1  resultado == 0.
- erro  out  1  illegal opcode or divide by zero.
- ocupado  out  1  high whenever the FSM is not in OCIOSO.

Behaviour:
- Reset state: FSM=OCIOSO, ultimo=1 so requester 0 wins the first tie.
- Reset values: all gnt/valido=0, ula_a=ula_b=0, ula_sel=00000, resultado=0, carry=0, zero=1, erro=0.
- FSM states: OCIOSO -> EXECUTA -> RESPONDE -> OCIOSO. Exactly one operation is in flight at a time.
- OCIOSO, no req: ula_sel=00000 and no grant is issued.
- OCIOSO, any req: pick the winner.
  - Only one req: that requester wins.
  - Both req: the requester not equal to ultimo wins.
- OCIOSO, on winning: gntK=1 for exactly that cycle; latch opK/aK/bK into internal registers; set ultimo=K; go to EXECUTA.
- Requester protocol: hold req and operands stable until the gnt cycle. req may drop or re-assert after that cycle. A req still high during EXECUTA/RESPONDE is ignored and is re-arbitrated in the next OCIOSO.
- EXECUTA: drive the latched operands onto ula_a/ula_b and the latched opcode onto ula_sel. At the clock edge, capture:
  - resultado = ula_saida.
  - carry = ula_carry only for ADD (00100) and MUL (00110); 0 for all other opcodes.
  - zero = (captured resultado == 0).
  - erro = 0.
  - Then go to RESPONDE.
- Legal opcodes: 00100 through 01101.
- Illegal opcode: ula_sel stays 00000 during EXECUTA; capture resultado=0, carry=0, zero=1, erro=1.
- DIV (00111) with b=0: the operation is still issued, but the captured values are overridden: resultado=0, carry=0, zero=1, erro=1.
- RESPONDE: valido of the latched winner =1 for exactly this cycle; ula_sel returns to 00000; go to OCIOSO.
- Latency: gnt in cycle N, valido in cycle N+2. A new grant is possible in N+3, so peak throughput is one operation per 3 cycles.
- Output holding: resultado/carry/zero/erro hold their values until the next EXECUTA capture.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1...
- rst asserted in any state: the next edge forces the reset values. An in-flight operation is dropped and no valido is issued for it.
- valido0 and valido1 are never high together; gnt0 and gnt1 are never high together.

Decomposition:
- Shared package ula_pkg holds the opcode constants OP_ADD=00100, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_NAND, OP_OR, OP_XOR, OP_CMP, OP_NOT=01101, and OP_NOP=00000.
- The package also holds the opcode-legality function and the FSM state encoding.
- One natural sub-module: arbitro_rr2, the two-way round-robin picker (req0, req1, ultimo -> vencedor, tem_vencedor). It is purely combinational; the FSM owns the ultimo register.

Test Plan:
- Reset, then req0 with op=00100, a=200, b=100 -> gnt0 one cycle later; valido0 two cycles after gnt0; resultado=44, carry=1, zero=0, erro=0.
- req0 and req1 high for 4 consecutive operations -> grant order 0,1,0,1; valido matches the winner every time; never two grants within 3 cycles.
- req1 with op=00111, a=9, b=0 -> resultado=0, zero=1, erro=1, carry=0. A following op=00101, a=5, b=5 -> resultado=0, zero=1, erro=0.
- req0 with op=11111 -> ula_sel stays 00000 throughout; resultado=0, erro=1; valido0 still pulses at N+2.
- req1 with op=01100, a=3, b=7 -> resultado=0xFF, carry=0. Then op=01101, a=0x0F -> resultado=0xF0.
- req0 granted, rst asserted in EXECUTA -> no valido0; all outputs at reset values; a subsequent tie between req0 and req1 grants requester 0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants, opcode legality
// and the arbiter FSM state encoding.
package ula_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_NAND = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    function automatic logic op_legal(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is chosen. Purely combinational; the caller owns the ultimo register.
module arbitro_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic ultimo,
    output logic vencedor,
    output logic tem_vencedor
);

    always_comb begin
        tem_vencedor = req0 | req1;
        if (req0 && req1) begin
            vencedor = ~ultimo;
        end else begin
            vencedor = req1;
        end
    end

endmodule

// File: rtl/ula_arbitro.sv
// Shares one combinational ALU between the control unit (0) and the
// auxiliary/DMA path (1): arbitrate, execute for one cycle, return result.
module ula_arbitro
    import ula_pkg::*;
#(
    parameter int LARGURA = 8,
    parameter int OP_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [OP_W-1:0]    op0,
    input  logic [LARGURA-1:0] a0,
    input  logic [LARGURA-1:0] b0,
    output logic               gnt0,
    output logic               valido0,
    input  logic               req1,
    input  logic [OP_W-1:0]    op1,
    input  logic [LARGURA-1:0] a1,
    input  logic [LARGURA-1:0] b1,
    output logic               gnt1,
    output logic               valido1,
    output logic [LARGURA-1:0] ula_a,
    output logic [LARGURA-1:0] ula_b,
    output logic [OP_W-1:0]    ula_sel,
    input  logic [LARGURA-1:0] ula_saida,
    input  logic               ula_carry,
    output logic [LARGURA-1:0] resultado,
    output logic               carry,
    output logic               zero,
    output logic               erro,
    output logic               ocupado
);

    estado_t            estado, proximo;
    logic               ultimo;
    logic               dono;
    logic               vencedor, tem_vencedor;
    logic               concede;
    logic [OP_W-1:0]    op_lat;
    logic [LARGURA-1:0] a_lat, b_lat;
    logic               legal, div_zero;

    arbitro_rr2 u_rr (
        .req0        (req0),
        .req1        (req1),
        .ultimo      (ultimo),
        .vencedor    (vencedor),
        .tem_vencedor(tem_vencedor)
    );

    assign legal    = op_legal(op_lat);
    assign div_zero = (op_lat == OP_DIV) && (b_lat == '0);
    assign concede  = (estado == OCIOSO) && tem_vencedor;

    always_comb begin
        proximo = estado;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        valido0 = 1'b0;
        valido1 = 1'b0;
        ula_a   = '0;
        ula_b   = '0;
        ula_sel = OP_NOP;
        case (estado)
            OCIOSO: begin
                if (tem_vencedor) begin
                    gnt0    = ~vencedor;
                    gnt1    = vencedor;
                    proximo = EXECUTA;
                end
            end
            EXECUTA: begin
                ula_a   = a_lat;
                ula_b   = b_lat;
                // an illegal opcode never reaches the ALU
                ula_sel = legal ? op_lat : OP_NOP;
                proximo = RESPONDE;
            end
            RESPONDE: begin
                valido0 = ~dono;
                valido1 = dono;
                proximo = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    assign ocupado = (estado != OCIOSO);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= OCIOSO;
            ultimo    <= 1'b1;
            dono      <= 1'b0;
            resultado <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
            erro      <= 1'b0;
        end else begin
            estado <= proximo;
            if (concede) begin
                ultimo <= vencedor;
                dono   <= vencedor;
            end
            if (estado == EXECUTA) begin
                if (!legal || div_zero) begin
                    resultado <= '0;
                    carry     <= 1'b0;
                    zero      <= 1'b1;
                    erro      <= 1'b1;
                end else begin
                    resultado <= ula_saida;
                    carry     <= ((op_lat == OP_ADD) || (op_lat == OP_MUL)) ? ula_carry : 1'b0;
                    zero      <= (ula_saida == '0);
                    erro      <= 1'b0;
                end
            end
        end
    end

    // operand latches are pure data and need no reset
    always_ff @(posedge clk) begin
        if (concede) begin
            op_lat <= vencedor ? op1 : op0;
            a_lat  <= vencedor ? a1 : a0;
            b_lat  <= vencedor ? b1 : b0;
        end
    end

endmodule
